// File: rtl/image_in_burst_writer.sv
// Converts a frame of FIFO words into fixed-length DDR write bursts (command + data beats).
// Optional IMG_WR_PINGPONG_EN alternates frames between base_addr0 and base_addr1.
module image_in_burst_writer #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 28,
  parameter int BURST_LEN = 16,
  parameter int FW_W      = 24
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              frame_start,
  input  logic [FW_W-1:0]   frame_words,
  input  logic [ADDR_W-1:0] base_addr0,
  input  logic [ADDR_W-1:0] base_addr1,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_rd_vld,
  output logic              fifo_rd_en,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_len,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [DATA_W-1:0] w_data,
  output logic              w_last,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic              buf_idx
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * DATA_W / 8);
  localparam logic [FW_W-1:0]   BURST_WORDS = FW_W'(BURST_LEN);

  state_t            state, state_nxt;
  logic [FW_W-1:0]   rem;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        beat_cnt;
  logic [ADDR_W-1:0] base_sel;
  logic              beat;
  logic              last_beat;
  logic              frame_go;

  function automatic logic [7:0] burst_len_m1(input logic [FW_W-1:0] words);
    if (words >= BURST_WORDS) return 8'(BURST_LEN - 1);
    return 8'(words - 1'b1);
  endfunction

`ifdef IMG_WR_PINGPONG_EN
  logic buf_q;
  assign base_sel = buf_q ? base_addr1 : base_addr0;
  assign buf_idx  = buf_q;

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst)              buf_q <= 1'b0;
    else if (state == DONE)  buf_q <= ~buf_q;
  end
`else
  logic unused_base1;
  assign unused_base1 = ^base_addr1;
  assign base_sel     = base_addr0;
  assign buf_idx      = 1'b0;
`endif

  // A beat and the FIFO pop are the same event.
  assign beat      = (state == DATA) & fifo_rd_vld & w_ready;
  assign last_beat = beat & (beat_cnt == 8'd0);
  assign frame_go  = (state == IDLE) & frame_start & (frame_words != '0);

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state      <= IDLE;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= (state == DONE);
      if (frame_start && (state != IDLE)) frame_err <= 1'b1;
    end
  end

  // Burst datapath: only observed through state-gated outputs, so no reset needed.
  always_ff @(posedge rd_clk) begin
    if (frame_go) begin
      rem  <= frame_words;
      addr <= base_sel;
    end
    if ((state == CMD) && cmd_ready) beat_cnt <= burst_len_m1(rem);
    if (beat) begin
      rem      <= rem - 1'b1;
      beat_cnt <= beat_cnt - 1'b1;
      if (beat_cnt == 8'd0) addr <= addr + BURST_BYTES;
    end
  end

  always_comb begin
    state_nxt  = state;
    cmd_valid  = 1'b0;
    cmd_addr   = '0;
    cmd_len    = '0;
    w_valid    = 1'b0;
    fifo_rd_en = 1'b0;
    w_data     = '0;
    w_last     = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (frame_start) state_nxt = (frame_words == '0) ? DONE : CMD;
      end
      CMD: begin
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = burst_len_m1(rem);
        if (cmd_ready) state_nxt = DATA;
      end
      DATA: begin
        w_valid    = fifo_rd_vld;
        fifo_rd_en = w_ready;
        w_data     = fifo_rd_data;
        w_last     = (beat_cnt == 8'd0);
        if (last_beat) state_nxt = (rem == FW_W'(1)) ? DONE : CMD;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_image_in_burst_writer.sv
// Bench for image_in_burst_writer: table-driven frames, hand-written corner sequences and random frames.
module tb_image_in_burst_writer;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 28;
  localparam int BURST_LEN = 16;
  localparam int FW_W      = 24;
  localparam int BYTES     = BURST_LEN * DATA_W / 8;
`ifdef IMG_WR_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic              rd_clk = 1'b0;
  logic              rd_rst;
  logic              frame_start;
  logic [FW_W-1:0]   frame_words;
  logic [ADDR_W-1:0] base_addr0, base_addr1;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_rd_vld, fifo_rd_en;
  logic              cmd_valid, cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  logic              w_valid, w_ready, w_last;
  logic [DATA_W-1:0] w_data;
  logic              busy, frame_done, frame_err, buf_idx;

  image_in_burst_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .FW_W(FW_W)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .frame_start(frame_start), .frame_words(frame_words),
    .base_addr0(base_addr0), .base_addr1(base_addr1), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_vld(fifo_rd_vld), .fifo_rd_en(fifo_rd_en), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .w_valid(w_valid),
    .w_ready(w_ready), .w_data(w_data), .w_last(w_last), .busy(busy),
    .frame_done(frame_done), .frame_err(frame_err), .buf_idx(buf_idx)
  );

  always #5 rd_clk = ~rd_clk;

  int n_checks = 0, n_fail = 0;
  int viol, done_cnt, cyc = 0;
  int crdy_mode, wrdy_mode, vld_mode, gap_left, cmd_wait;
  logic [DATA_W-1:0] next_word;
  logic [ADDR_W-1:0] q_addr[$];
  logic [7:0]        q_len[$];
  logic [DATA_W-1:0] q_data[$];
  logic              q_last[$];
  bit                prev_hold;
  logic [ADDR_W-1:0] prev_addr;
  logic [7:0]        prev_len;
  bit                exp_buf;

  typedef struct {
    int                words;
    logic [ADDR_W-1:0] base0;
    logic [ADDR_W-1:0] base1;
    int                crdy;
    int                wrdy;
    int                vld;
    int                exp_cmds;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_inputs();
    case (crdy_mode)
      0:       cmd_ready = 1'b1;
      1:       cmd_ready = (cmd_wait >= 5);
      default: cmd_ready = 1'($urandom_range(0, 1));
    endcase
    case (wrdy_mode)
      0:       w_ready = 1'b1;
      1:       w_ready = ((cyc % 2) == 0);
      default: w_ready = 1'($urandom_range(0, 1));
    endcase
    case (vld_mode)
      0: fifo_rd_vld = 1'b1;
      3: begin
        if (q_data.size() == 5 && gap_left > 0) begin
          fifo_rd_vld = 1'b0;
          gap_left--;
        end else fifo_rd_vld = 1'b1;
      end
      default: fifo_rd_vld = ($urandom_range(0, 9) < 7);
    endcase
    fifo_rd_data = next_word;
  endtask

  // One clock: drive, sample just after the inputs settle, then advance to the next falling edge.
  task automatic cycle();
    drive_inputs();
    #1;
    if (prev_hold && !(cmd_valid && cmd_addr == prev_addr && cmd_len == prev_len)) viol++;
    prev_hold = cmd_valid && !cmd_ready;
    prev_addr = cmd_addr;
    prev_len  = cmd_len;
    if (cmd_valid && frame_done) viol++;
    if (w_valid && !fifo_rd_vld) viol++;
    if (fifo_rd_en && !w_ready) viol++;
    if ((w_valid && w_ready) != (fifo_rd_vld && fifo_rd_en)) viol++;
    if (w_valid && w_data !== fifo_rd_data) viol++;
    if (cmd_valid && cmd_ready) begin
      q_addr.push_back(cmd_addr);
      q_len.push_back(cmd_len);
      cmd_wait = 0;
    end else if (cmd_valid) cmd_wait++;
    else cmd_wait = 0;
    if (w_valid && w_ready) begin
      q_data.push_back(w_data);
      q_last.push_back(w_last);
    end
    if (frame_done) done_cnt++;
    if (fifo_rd_vld && fifo_rd_en) next_word = next_word + 1;
    @(posedge rd_clk);
    @(negedge rd_clk);
    cyc++;
  endtask

  task automatic start_frame(input int words);
    frame_words = FW_W'(words);
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
  endtask

  task automatic clear_obs();
    q_addr.delete(); q_len.delete(); q_data.delete(); q_last.delete();
    done_cnt = 0; viol = 0; cmd_wait = 0; gap_left = 3;
  endtask

  // Runs one frame to completion and compares against the burst-splitting rules.
  task automatic run_frame(input int words, input logic [ADDR_W-1:0] b0, input logic [ADDR_W-1:0] b1,
                           input int exp_cmds, input string tag);
    logic [ADDR_W-1:0] base, ea;
    logic [DATA_W-1:0] first;
    int ncmd, left;
    base_addr0 = b0;
    base_addr1 = b1;
    base = (PP && exp_buf) ? b1 : b0;
    clear_obs();
    next_word = $urandom;
    first = next_word;
    start_frame(words);
    chk({tag, "_cmd_valid_n1"}, 64'(cmd_valid), 64'd1);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) cycle();
    chk({tag, "_done_seen"}, 64'(done_cnt), 64'd1);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    cycle();
    chk({tag, "_done_once"}, 64'(done_cnt + 32'(frame_done)), 64'd1);
    if (PP) exp_buf = !exp_buf;
    chk({tag, "_buf_idx"}, 64'(buf_idx), 64'(exp_buf));
    ncmd = (words + BURST_LEN - 1) / BURST_LEN;
    chk({tag, "_ncmd"}, 64'(q_addr.size()), 64'(exp_cmds));
    chk({tag, "_npops"}, 64'(q_data.size()), 64'(words));
    for (int k = 0; k < ncmd && k < q_addr.size(); k++) begin
      ea   = base + ADDR_W'(k * BYTES);
      left = words - k * BURST_LEN;
      chk({tag, "_cmd_addr"}, 64'(q_addr[k]), 64'(ea));
      chk({tag, "_cmd_len"}, 64'(q_len[k]), 64'(((left >= BURST_LEN) ? BURST_LEN : left) - 1));
    end
    for (int i = 0; i < words && i < q_data.size(); i++) begin
      chk({tag, "_data"}, 64'(q_data[i]), 64'(first + DATA_W'(i)));
      chk({tag, "_last"}, 64'(q_last[i]), 64'(((i % BURST_LEN) == BURST_LEN - 1) || (i == words - 1)));
    end
    chk({tag, "_protocol"}, 64'(viol), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
    chk({tag, "_cmd_addr"}, 64'(cmd_addr), 64'd0);
    chk({tag, "_cmd_len"}, 64'(cmd_len), 64'd0);
    chk({tag, "_w_valid"}, 64'(w_valid), 64'd0);
    chk({tag, "_w_data"}, 64'(w_data), 64'd0);
    chk({tag, "_w_last"}, 64'(w_last), 64'd0);
    chk({tag, "_fifo_rd_en"}, 64'(fifo_rd_en), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
    chk({tag, "_frame_err"}, 64'(frame_err), 64'd0);
    chk({tag, "_buf_idx"}, 64'(buf_idx), 64'd0);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{48, 28'h1000,    28'h8000, 0, 0, 0, 3};
    vecs[1] = '{20, 28'h1000,    28'h8000, 0, 0, 0, 2};
    vecs[2] = '{40, 28'h1000,    28'h8000, 1, 1, 0, 3};
    vecs[3] = '{16, 28'h1000,    28'h8000, 0, 0, 3, 1};
    vecs[4] = '{1,  28'h1000,    28'h8000, 0, 0, 0, 1};
    vecs[5] = '{17, 28'h1000,    28'h8000, 2, 2, 2, 2};
    vecs[6] = '{40, 28'hFFFFFC0, 28'hFFFFFC0, 0, 0, 0, 3};

    rd_rst = 1'b1; frame_start = 1'b0; frame_words = '0;
    base_addr0 = 28'h1000; base_addr1 = 28'h8000;
    fifo_rd_data = 32'hA5A5A5A5; fifo_rd_vld = 1'b1; cmd_ready = 1'b1; w_ready = 1'b1;
    crdy_mode = 0; wrdy_mode = 0; vld_mode = 0; exp_buf = 1'b0; prev_hold = 1'b0;
    next_word = '0;
    clear_obs();
    @(negedge rd_clk); @(negedge rd_clk);
    check_all_zero("reset");
    rd_rst = 1'b0;
    @(negedge rd_clk);

    // Back-to-back frames: buffer alternation when ping-pong is built in.
    run_frame(16, 28'h1000, 28'h8000, 1, "pp1");
    chk("pp1_first_addr", (q_addr.size() > 0) ? 64'(q_addr[0]) : 64'hDEAD, 64'h1000);
    run_frame(16, 28'h1000, 28'h8000, 1, "pp2");
    chk("pp2_first_addr", (q_addr.size() > 0) ? 64'(q_addr[0]) : 64'hDEAD, PP ? 64'h8000 : 64'h1000);

    for (int v = 0; v < 7; v++) begin
      crdy_mode = vecs[v].crdy; wrdy_mode = vecs[v].wrdy; vld_mode = vecs[v].vld;
      run_frame(vecs[v].words, vecs[v].base0, vecs[v].base1, vecs[v].exp_cmds, $sformatf("vec%0d", v));
    end

    for (int r = 0; r < 8; r++) begin
      int w;
      crdy_mode = $urandom_range(0, 2); wrdy_mode = $urandom_range(0, 2); vld_mode = $urandom_range(0, 2);
      w = $urandom_range(1, 70);
      run_frame(w, ADDR_W'($urandom), ADDR_W'($urandom), (w + BURST_LEN - 1) / BURST_LEN,
                $sformatf("rnd%0d", r));
    end

    // frame_start while busy, then asynchronous reset mid-burst.
    crdy_mode = 0; wrdy_mode = 0; vld_mode = 0;
    clear_obs();
    start_frame(48);
    for (int i = 0; i < 200 && q_data.size() < 5; i++) cycle();
    frame_words = FW_W'(7);
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    chk("err_sticky_set", 64'(frame_err), 64'd1);
    chk("err_busy_kept", 64'(busy), 64'd1);
    cycle(); cycle();
    chk("err_still_set", 64'(frame_err), 64'd1);
    chk("mid_burst_wvalid", 64'(w_valid), 64'd1);
    #2 rd_rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(posedge rd_clk); @(negedge rd_clk);
    rd_rst = 1'b0;
    prev_hold = 1'b0; exp_buf = 1'b0;

    // Zero-length frame: no command, frame_done two cycles after frame_start.
    clear_obs();
    start_frame(0);
    chk("zero_cmd_valid_n1", 64'(cmd_valid), 64'd0);
    chk("zero_done_n1", 64'(frame_done), 64'd0);
    chk("zero_busy_n1", 64'(busy), 64'd1);
    cycle();
    chk("zero_done_n2", 64'(frame_done), 64'd1);
    chk("zero_busy_n2", 64'(busy), 64'd0);
    cycle();
    chk("zero_done_pulse_count", 64'(done_cnt), 64'd1);
    chk("zero_no_cmd", 64'(q_addr.size()), 64'd0);
    chk("zero_buf_idx", 64'(buf_idx), 64'(PP));
    chk("zero_err_clear", 64'(frame_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
